// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button conditioner.
// btn_state_t  : per-channel debounce FSM state
// DEF_*        : defaults for a 65 MHz pixel clock (10 ms debounce, 400 ms
//                repeat delay, 100 ms repeat rate)
// max_u        : constant-foldable maximum used for counter sizing
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_CLK_HZ              = 65_000_000;
    localparam int unsigned DEF_SYNC_STAGES         = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 650_000;
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 26_000_000;
    localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 6_500_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle of board-button signals between the pins and the game logic.
// btn_raw     : raw asynchronous pins (driven by the board side)
// btn_level   : debounced level per channel
// btn_press   : one-cycle press / auto-repeat pulse per channel
// btn_release : one-cycle release pulse per channel
// any_pressed : registered OR of btn_level
// master = board/consumer side, slave = the conditioner itself.
interface btn_conditioner_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_pressed;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_pressed
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_pressed
    );
endinterface

// File: rtl/btn_channel.sv
// One button channel: synchroniser chain, debounce FSM, debounce counter and
// auto-repeat counter.
// clk         : pixel clock
// rst_n       : synchronous active-low reset
// btn_raw     : raw asynchronous pin
// btn_level   : registered debounced level
// btn_press   : registered one-cycle press / repeat pulse
// btn_release : registered one-cycle release pulse
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
    parameter bit          REPEAT_EN           = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_W =
        $clog2(max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES - 1);

    // Synchroniser: only its last stage feeds the FSM.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc, rep_target;
    logic             rep_first_q, rep_first_d;  // 1 until the first repeat has fired
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    // Saturating increments; counters never wrap.
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign rep_inc    = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
    assign rep_target = rep_first_q ? DELAY_LAST : RATE_LAST;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end
            end

            PRESS_PEND: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (rep_cnt_q == rep_target) begin
                        press_d     = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
                end
            end

            RELEASE_PEND: begin
                // A short low glitch returns to PRESSED with the repeat phase intact.
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Board push-button front end: N_BTN independent debounced channels plus a
// registered any_pressed flag, all in the pixel-clock domain.
// clk   : pixel clock, the only clock
// rst_n : synchronous active-low reset
// bus   : btn_conditioner_if.slave (btn_raw in; btn_level, btn_press,
//         btn_release, any_pressed out)
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned      N_BTN               = 3,
    parameter int unsigned      SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int unsigned      DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned      REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned      REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
    parameter logic [N_BTN-1:0] REPEAT_MASK         = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    btn_conditioner_if.slave   bus
);

    if (N_BTN < 1) begin : g_bad_n_btn
        $fatal(1, "btn_conditioner: N_BTN must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "btn_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY_CYCLES < 1) begin : g_bad_delay
        $fatal(1, "btn_conditioner: REPEAT_DELAY_CYCLES must be >= 1");
    end
    if (REPEAT_RATE_CYCLES < 1) begin : g_bad_rate
        $fatal(1, "btn_conditioner: REPEAT_RATE_CYCLES must be >= 1");
    end

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_p;
    logic             any_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES         (SYNC_STAGES),
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
            .REPEAT_EN           (REPEAT_MASK[i])
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (bus.btn_raw[i]),
            .btn_level   (level[i]),
            .btn_press   (press[i]),
            .btn_release (release_p[i])
        );
    end

    // Lags btn_level by one cycle since it is built from the registered levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |level;
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = release_p;
    assign bus.any_pressed = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: each stimulus step pushes the expected
// outputs for the cycles it affects; a monitor pops and compares them one time
// unit after each rising edge.
module tb_btn_conditioner;

    localparam int unsigned N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN               (N),
        .SYNC_STAGES         (2),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (3),
        .REPEAT_MASK         (3'b010)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        int             cyc;
        logic [N-1:0]   press;
        logic [N-1:0]   rel;
        logic [N-1:0]   level;
        logic           any;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input int c, input logic [N-1:0] p,
                            input logic [N-1:0] r, input logic [N-1:0] l, input logic a);
        exp_t e;
        e.tag   = tag;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.level = l;
        e.any   = a;
        sb_q.push_back(e);
    endtask

    // Monitor: entries are tagged with the edge count after which they hold.
    always @(posedge clk) begin
        #1;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc != cyc) begin
                check_eq({e.tag, ".stale"}, e.cyc, cyc);
            end else begin
                check_eq({e.tag, ".press"},   bus.btn_press,   e.press);
                check_eq({e.tag, ".release"}, bus.btn_release, e.rel);
                check_eq({e.tag, ".level"},   bus.btn_level,   e.level);
                check_eq({e.tag, ".any"},     bus.any_pressed, e.any);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.btn_raw = '0;
        push_exp("reset", cyc + 1, 3'b000, 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish (checks=%0d)", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int r;
        logic rp;
        bus.btn_raw = '0;
        repeat (2) @(negedge clk);

        // Clean press on channel 0.
        do_reset();
        @(negedge clk);
        bus.btn_raw = 3'b001;
        t = cyc;
        for (int c = t + 1; c <= t + 12; c++) begin
            push_exp("press", c, (c == t + 7) ? 3'b001 : 3'b000, 3'b000,
                     (c >= t + 7) ? 3'b001 : 3'b000, c >= t + 8);
        end
        repeat (12) @(negedge clk);

        // Two-cycle low glitch while pressed: no release.
        bus.btn_raw = 3'b000;
        t = cyc;
        for (int c = t + 1; c <= t + 10; c++) begin
            push_exp("glitch_lo", c, 3'b000, 3'b000, 3'b001, 1'b1);
        end
        repeat (2) @(negedge clk);
        bus.btn_raw = 3'b001;
        repeat (8) @(negedge clk);

        // Real release.
        bus.btn_raw = 3'b000;
        t = cyc;
        for (int c = t + 1; c <= t + 10; c++) begin
            push_exp("release", c, 3'b000, (c == t + 7) ? 3'b001 : 3'b000,
                     (c < t + 7) ? 3'b001 : 3'b000, c <= t + 7);
        end
        repeat (10) @(negedge clk);

        // Bounce 1,0,1,0 then a 3-cycle high glitch: nothing accepted.
        do_reset();
        @(negedge clk);
        t = cyc;
        for (int c = t + 1; c <= t + 16; c++) begin
            push_exp("bounce", c, 3'b000, 3'b000, 3'b000, 1'b0);
        end
        bus.btn_raw = 3'b001;
        @(negedge clk);
        bus.btn_raw = 3'b000;
        @(negedge clk);
        bus.btn_raw = 3'b001;
        @(negedge clk);
        bus.btn_raw = 3'b000;
        repeat (2) @(negedge clk);
        bus.btn_raw = 3'b001;
        repeat (3) @(negedge clk);
        bus.btn_raw = 3'b000;
        repeat (8) @(negedge clk);

        // Auto-repeat on channel 1; channel 0 held alongside fires once.
        do_reset();
        @(negedge clk);
        bus.btn_raw = 3'b011;
        t = cyc;
        for (int c = t + 1; c <= t + 25; c++) begin
            rp = (c == t + 7) || (c >= t + 17 && ((c - t - 17) % 3) == 0);
            push_exp("repeat", c, {1'b0, rp, c == t + 7}, 3'b000,
                     (c >= t + 7) ? 3'b011 : 3'b000, c >= t + 8);
        end
        repeat (25) @(negedge clk);

        // One-cycle reset while repeating; raw stays high so a fresh press follows.
        rst_n = 1'b0;
        r = cyc + 1;
        push_exp("mid_reset", r, 3'b000, 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = r + 1; c <= r + 9; c++) begin
            push_exp("post_reset", c, (c == r + 7) ? 3'b011 : 3'b000, 3'b000,
                     (c >= r + 7) ? 3'b011 : 3'b000, c >= r + 8);
        end
        repeat (9) @(negedge clk);

        // All three channels pressed and released together.
        do_reset();
        @(negedge clk);
        bus.btn_raw = 3'b111;
        t = cyc;
        for (int c = t + 1; c <= t + 10; c++) begin
            push_exp("simul_press", c, (c == t + 7) ? 3'b111 : 3'b000, 3'b000,
                     (c >= t + 7) ? 3'b111 : 3'b000, c >= t + 8);
        end
        repeat (10) @(negedge clk);
        bus.btn_raw = 3'b000;
        t = cyc;
        for (int c = t + 1; c <= t + 10; c++) begin
            push_exp("simul_release", c, 3'b000, (c == t + 7) ? 3'b111 : 3'b000,
                     (c < t + 7) ? 3'b111 : 3'b000, c <= t + 7);
        end
        repeat (10) @(negedge clk);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Parametrised board-input front end for the Basys3 top level. It takes N raw push-button pins (btnC/btnU/btnD and later additions) and produces clean per-channel signals in the pixel-clock domain: a synchronised and debounced level, a one-cycle press pulse, a one-cycle release pulse, and optional auto-repeat press pulses while a button is held. It sits between the board pins and top_vga, replacing direct wiring of raw buttons into game logic.

Parameters:
N_BTN, 3, number of button channels
SYNC_STAGES, 2, synchroniser flop depth; must be >= 2
DEBOUNCE_CYCLES, 650000, stable cycles required to accept a level change (10 ms at 65 MHz); must be >= 1
REPEAT_DELAY_CYCLES, 26000000, cycles from the first press pulse to the first repeat pulse (400 ms)
REPEAT_RATE_CYCLES, 6500000, cycles between successive repeat pulses (100 ms); must be >= 1
REPEAT_MASK, {N_BTN{1'b0}}, bit i = 1 enables auto-repeat on channel i

Ports:
clk  in  1  pixel clock (65 MHz), the only clock
rst_n  in  1  synchronous, active-low reset
btn_raw  in  N_BTN  asynchronous raw button pins, active-high
btn_level  out  N_BTN  debounced button state
btn_press  out  N_BTN  one-cycle pulse on an accepted press and on each auto-repeat
btn_release  out  N_BTN  one-cycle pulse on an accepted release
any_pressed  out  1  OR of btn_level, registered

Behaviour:
- Clocking and reset: one clock and one reset. Reset is synchronous and active-low. While rst_n = 0 at a clk edge, all synchroniser flops, counters and outputs are cleared to 0 and every FSM goes to RELEASED. Reset takes priority over all other events. Reset asserted mid-debounce or mid-hold drops btn_level to 0 with no release pulse.
- Synchroniser: btn_raw[i] passes through a SYNC_STAGES flop chain. The output of the chain is s[i]. Nothing downstream uses btn_raw directly.
- Per-channel FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED: if s = 1, go to PRESS_PEND and set cnt = 0.
  - PRESS_PEND: if s = 0, return to RELEASED (a bounce; no pulse). Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to PRESSED, set btn_level = 1, fire btn_press, and set rep_cnt = 0. Otherwise increment cnt.
  - PRESSED: if s = 0, go to RELEASE_PEND and set cnt = 0. Otherwise, when REPEAT_MASK[i] = 1, increment rep_cnt. Fire btn_press when rep_cnt reaches REPEAT_DELAY_CYCLES-1 for the first repeat, then every REPEAT_RATE_CYCLES-1 for later repeats; rep_cnt restarts at 0 after each repeat pulse.
  - RELEASE_PEND: if s = 1, return to PRESSED. btn_level stays 1, no pulse, and the repeat phase resumes with rep_cnt held. Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to RELEASED, set btn_level = 0 and fire btn_release. Otherwise increment cnt.
- Latency: with btn_raw stable high from the first sampling edge E, btn_press is high during the cycle after edge E + SYNC_STAGES + DEBOUNCE_CYCLES. Release latency is identical.
- Outputs: all outputs are registered. Each pulse lasts exactly 1 cycle. btn_press and btn_release are never both high on the same channel.
- Repeat phase: the repeat counter is not advanced in RELEASE_PEND.
- Counter widths: cnt uses $clog2(DEBOUNCE_CYCLES+1) bits. rep_cnt uses $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1) bits. Counters saturate and never wrap.
- Channel independence: channels are fully independent, so simultaneous presses on several channels produce pulses in the same cycle.
- any_pressed is updated one cycle after btn_level.
- Elaboration: illegal parameter values trigger a $fatal at elaboration.

Decomposition:
- Package btn_pkg holds:
  - the state typedef (btn_state_t: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND);
  - localparam defaults for the 65 MHz timing constants.
- Sub-module btn_channel (synchroniser, FSM and counters for one button) is instantiated N_BTN times in a generate loop.
- The top module only adds the any_pressed reduction.

Test Plan:
All tests use N_BTN=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3, REPEAT_MASK=3'b010.
- Clean press: btn_raw[0] rises before edge 1 and stays high -> btn_press[0] pulses for exactly 1 cycle after edge 7; btn_level[0] = 1 from edge 7; any_pressed = 1 from edge 8.
- Bounce rejection: btn_raw[0] toggles 1,0,1,0 on successive cycles, then stays 0 -> no btn_press, btn_level[0] remains 0; a glitch lasting 3 cycles is also rejected.
- Release: after a clean press, btn_raw[0] falls -> btn_release[0] pulses 7 edges later and btn_level[0] = 0; a 2-cycle low glitch while pressed produces no release pulse.
- Auto-repeat: btn_raw[1] held -> press pulses after edges 7, 17, 20 and 23; channel 0 held the same way pulses only once.
- Simultaneous events: btn_raw = 3'b111 rises in the same cycle -> all three btn_press bits pulse in the same cycle; releasing them together gives simultaneous btn_release pulses.
- Reset mid-operation: rst_n = 0 for 1 cycle while channel 1 is PRESSED and repeating -> next cycle all outputs are 0 with no release pulse; if raw is still high, a fresh press pulse follows 7 edges after rst_n returns to 1.
